unidad_banderas: RTL

Registered, parametrised ALU status-flag unit for the CPU datapath. Takes the ALU operands, result and operation select each cycle. Computes N, Z, C and V (signed overflow) for WIDTH-bit add and subtract, and holds them in a flags register for the branch/condition logic. Adds what single-cycle overflow detection cannot provide: conditional flag writes, multi-word zero chaining, a sticky overflow bit and a saturating overflow-event counter.

---
 rtl/unidad_banderas_pkg.sv | 20 ++
 rtl/unidad_banderas_calc.sv | 60 ++++++
 rtl/unidad_banderas.sv | 98 +++++++++
 3 files changed

// File: rtl/unidad_banderas_pkg.sv
// Shared definitions for the ALU status-flag unit: opcodes, flag record, bit positions.
package banderas_pkg;

  localparam logic [2:0] OP_SUMA  = 3'b000;
  localparam logic [2:0] OP_RESTA = 3'b001;

  // Packed so that {n,z,c,v} lines up with flags_o[3:0].
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int unsigned FLAG_N = 32'd3;
  localparam int unsigned FLAG_Z = 32'd2;
  localparam int unsigned FLAG_C = 32'd1;
  localparam int unsigned FLAG_V = 32'd0;

endpackage

// File: rtl/unidad_banderas_calc.sv
// Combinational next-flag calculation from operand/result sign bits and result value.
module calc_banderas
  import banderas_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [2:0]       sel_i,
  input  logic             chain_i,
  input  logic             z_q_i,
  input  logic             c_q_i,
  input  logic             v_q_i,
  output flags_t           flags_d_o,
  output logic             ovf_o
);

  logic arith_s;
  logic sub_s;
  logic a_msb_s;
  logic b_eff_s;
  logic c_msb_s;
  logic zraw_s;
  logic v_next_s;
  logic c_next_s;

  // Only the sign bits of the operands matter; low bits are deliberately ignored.
  logic unused_low_bits;
  assign unused_low_bits = ^{a_i[WIDTH-2:0], b_i[WIDTH-2:0]};

  // Derive N, Z, C, V; C and V keep their stored value on non-arithmetic ops.
  always_comb begin
    arith_s  = (sel_i[2:1] == 2'b00);
    sub_s    = sel_i[0];
    a_msb_s  = a_i[WIDTH-1];
    // Subtraction is an add of the inverted B operand, so one carry formula serves both.
    b_eff_s  = b_i[WIDTH-1] ^ sub_s;
    c_msb_s  = c_i[WIDTH-1];
    zraw_s   = (c_i == {WIDTH{1'b0}});
    v_next_s = arith_s & ~(a_msb_s ^ b_eff_s) & (a_msb_s ^ c_msb_s);
    c_next_s = (a_msb_s & b_eff_s) | ((a_msb_s | b_eff_s) & ~c_msb_s);

    flags_d_o.n = c_msb_s;
    if (chain_i) begin
      flags_d_o.z = z_q_i & zraw_s;
    end else begin
      flags_d_o.z = zraw_s;
    end
    if (arith_s) begin
      flags_d_o.c = c_next_s;
      flags_d_o.v = v_next_s;
    end else begin
      flags_d_o.c = c_q_i;
      flags_d_o.v = v_q_i;
    end
    ovf_o = v_next_s;
  end

endmodule

// File: rtl/unidad_banderas.sv
// Registered NZCV flag unit with conditional writes, Z chaining, sticky overflow and event counter.
module unidad_banderas
  import banderas_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             set_flags_i,
  input  logic             chain_i,
  input  logic [2:0]       sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic             clr_sticky_i,
  output logic [3:0]       flags_o,
  output logic             sticky_v_o,
  output logic [CNT_W-1:0] ovf_count_o,
  output logic             valid_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  flags_t           flags_q, flags_d, calc_flags_s;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q;
  logic             ovf_s;
  logic             upd_s;
  logic             evt_s;

  calc_banderas #(.WIDTH(WIDTH)) u_calc (
    .a_i      (a_i),
    .b_i      (b_i),
    .c_i      (c_i),
    .sel_i    (sel_i),
    .chain_i  (chain_i),
    .z_q_i    (flags_q.z),
    .c_q_i    (flags_q.c),
    .v_q_i    (flags_q.v),
    .flags_d_o(calc_flags_s),
    .ovf_o    (ovf_s)
  );

  // Next-state for flags, sticky bit and saturating counter; an event wins over a clear.
  always_comb begin
    upd_s   = valid_i & set_flags_i;
    evt_s   = upd_s & ovf_s;
    flags_d = flags_q;
    if (upd_s) begin
      flags_d = calc_flags_s;
    end else begin
      flags_d = flags_q;
    end

    sticky_d = sticky_q;
    if (evt_s) begin
      sticky_d = 1'b1;
    end else if (clr_sticky_i) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end

    cnt_d = cnt_q;
    if (clr_sticky_i) begin
      cnt_d = evt_s ? CNT_ONE : {CNT_W{1'b0}};
    end else if (evt_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset clears everything, including any chain in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= '{n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};
      sticky_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_i;
    end
  end

  assign flags_o     = flags_q;
  assign sticky_v_o  = sticky_q;
  assign ovf_count_o = cnt_q;
  assign valid_o     = valid_q;

endmodule
